rr_onehot_arbiter: RTL and testbench
====================================

# rr_onehot_arbiter

Round-robin arbiter that selects one of `width` requesters each cycle and issues the winner as a registered one-hot grant plus its binary index, behind a valid/ready handshake. Internally it produces the one-hot vector and converts it to an index with the existing `Encode` module. It sits directly upstream of any index consumer, such as a mux select or a result-bus tag, and guarantees the exactly-one-hot condition that `Encode` requires.

## Interface
- `width`, default 8: number of requesters; legal range 2..256.
- `CLK` input 1: clock; all state is rising-edge.
- `RSTN` input 1: asynchronous, active-low reset.
- `Req` input `width`: request vector; any number of bits may be set.
- `Valid` output 1: a grant is held on `Grant`/`Idx`.
- `Ready` input 1: the consumer accepts the grant when `Valid && Ready`.
- `Grant` output `width`: registered grant, exactly one-hot when `Valid`, all-zero otherwise.
- `Idx` output `$clog2(width)`: binary position of the set `Grant` bit; 0 when `!Valid`.

One clock; reset is asynchronous and active-low.

## Operation
- State:
  - Output register: `Valid`, `Grant`, `Idx`.
  - Priority pointer `ptr`, width `$clog2(width)`.
- Load condition: `load = !Valid || Ready`.
  - If `load` is low (stall), all state holds and `Req` is ignored.
- Effective pointer: `eptr = (Valid && Ready) ? wrap(Idx+1) : ptr`.
  - `wrap(x) = (x == width) ? 0 : x`, which covers non-power-of-two `width`.
- Selection: the winner is the first set `Req` bit found scanning upward from `eptr`, wrapping past `width-1` to 0.
- On `load`:
  - Any `Req` bit set: `Valid`←1, `Grant`←winner one-hot, `Idx`←winner.
  - `Req` all-zero: `Valid`←0, `Grant`←0, `Idx`←0.
- Pointer update: on `Valid && Ready`, `ptr`←`wrap(Idx+1)`. Otherwise `ptr` holds.
- Requests are not latched. A requester that drops `Req` before being granted simply loses its turn. A granted requester is not checked for still requesting.
- Reset mid-transaction: the held grant is discarded and nothing is replayed.

## Timing
- Reset values: `Valid`=0, `Grant`=0, `Idx`=0, `ptr`=0.
- Latency: a request present in cycle N with `load`=1 appears on `Grant`/`Idx` in cycle N+1.
- Throughput: one grant per cycle while `Ready` is held high.
- Back-to-back: a handshake and a new selection happen in the same cycle. The new selection uses the post-handshake pointer, so the just-served requester has lowest priority.
- Stall: while `Valid && !Ready`, `Grant`/`Idx`/`Valid` are stable, independent of `Req` changes.
- `Ready` may be high while `Valid`=0; this has no effect other than allowing a load.
- No combinational path from `Req` or `Ready` to any output.

## Configuration
- `ELAU_RRARB_FAIR_EN` defined:
  - Round-robin as above.
- `ELAU_RRARB_FAIR_EN` undefined:
  - Fixed priority: the lowest set index always wins (`eptr` ≡ 0).
  - The `ptr` register and its update logic are not built.
  - Handshake, latency and reset behaviour are unchanged.

## Structure
- Shared package `elau_arb_pkg`:
  - Function `wrap_inc(idx, width)`.
  - Localparam helper for the index width, `$clog2(width)`, reused by the arbiter and its consumers.
- Sub-module: `Encode` converts the combinational one-hot winner to the binary index before the output register.
  - No other sub-modules.
  - The rotate-and-priority-select logic stays inline.

## Test plan
- Reset and idle:
  - Assert `RSTN`=0 mid-grant → `Valid`/`Grant`/`Idx`/`ptr` read 0 immediately, without waiting for a clock edge.
  - `Req`=0 after release → `Valid` stays 0.
- Rotation, `width`=8, `Req`=8'hFF, `Ready`=1 → `Idx` sequence 0,1,…,7,0. `Grant` equals `1<<Idx` every cycle.
- Stall:
  - `Req`=8'h12, `Ready`=0 → `Grant`=8'h02 (`Idx`=1) held for 5 cycles, even after `Req` changes to 8'h80.
  - Raise `Ready` → next grant is `Idx`=7.
- Wrap with non-power-of-two `width`=5, `Req`=5'b10001, `Ready`=1 → `Idx` alternates 0,4,0,4. The pointer never reaches 5.
- Dropped request, `Req`=8'h0C:
  - Grant `Idx`=2, then `Req` becomes 8'h00 → `Valid` falls to 0 one cycle after the handshake.
  - A later `Req`=8'h04 → `Idx`=2 again.
- Macro off: same stimulus as the rotation test, `ELAU_RRARB_FAIR_EN` undefined → `Idx`=0 every cycle.

Source files
------------

// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared arbiter helpers: index-width sizing and the pointer wrap-increment
// used by rr_onehot_arbiter and by any consumer of its grant index.
package elau_arb_pkg;

  localparam int ARB_WIDTH_DEF = 8;

  // Index width for a given requester count; never narrower than one bit.
  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Next index after idx, folding back to 0 for non-power-of-two widths.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned width);
    return (idx + 32'd1 == width) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between requesters/consumer (master) and the arbiter (slave).
interface rr_onehot_arbiter_if
  import elau_arb_pkg::*;
#(
  parameter int width = ARB_WIDTH_DEF
);
  localparam int IW = idx_w(width);

  logic [width-1:0] Req;
  logic             Ready;
  logic             Valid;
  logic [width-1:0] Grant;
  logic [IW-1:0]    Idx;

  modport master (output Req, output Ready, input Valid, input Grant, input Idx);
  modport slave  (input Req, input Ready, output Valid, output Grant, output Idx);

endinterface

// File: rtl/rr_onehot_arbiter_encode.sv
// One-hot to binary encoder; the input must be one-hot or all-zero.
module Encode
  import elau_arb_pkg::*;
#(
  parameter int width = ARB_WIDTH_DEF,
  localparam int IW   = idx_w(width)
) (
  input  logic [width-1:0] i_onehot,
  output logic [IW-1:0]    o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < width; i++) begin
      if (i_onehot[i]) o_idx = o_idx | IW'(i);
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Registered one-hot arbiter behind a valid/ready handshake. Round-robin when
// ELAU_RRARB_FAIR_EN is defined, otherwise fixed lowest-index priority.
module rr_onehot_arbiter
  import elau_arb_pkg::*;
#(
  parameter int width = ARB_WIDTH_DEF
) (
  input  logic               CLK,
  input  logic               RSTN,
  rr_onehot_arbiter_if.slave bus
);

  localparam int IW = idx_w(width);

  logic             r_valid;
  logic [width-1:0] r_grant;
  logic [IW-1:0]    r_idx;

  logic             w_load;
  logic [IW-1:0]    w_eptr;
  logic [IW:0]      w_pos;
  logic [width-1:0] w_win;
  logic             w_found;
  logic [IW-1:0]    w_win_idx;

  assign w_load = !r_valid || bus.Ready;

`ifdef ELAU_RRARB_FAIR_EN
  logic          w_hs;
  logic [IW-1:0] w_next_ptr;
  logic [IW-1:0] r_ptr;

  assign w_hs       = r_valid && bus.Ready;
  assign w_next_ptr = IW'(wrap_inc(32'(r_idx), width));
  // Served requester drops to lowest priority in the same cycle it is accepted.
  assign w_eptr     = w_hs ? w_next_ptr : r_ptr;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)     r_ptr <= '0;
    else if (w_hs) r_ptr <= w_next_ptr;
  end
`else
  assign w_eptr = '0;
`endif

  // Scan upward from w_eptr, wrapping at width rather than at 2**IW.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < width; k++) begin
      w_pos = {1'b0, w_eptr} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(width)) w_pos = w_pos - (IW+1)'(width);
      if (!w_found && bus.Req[w_pos[IW-1:0]]) begin
        w_win[w_pos[IW-1:0]] = 1'b1;
        w_found              = 1'b1;
      end
    end
  end

  Encode #(.width(width)) u_encode (
    .i_onehot (w_win),
    .o_idx    (w_win_idx)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_valid <= 1'b0;
      r_grant <= '0;
      r_idx   <= '0;
    end else if (w_load) begin
      r_valid <= w_found;
      r_grant <= w_win;
      r_idx   <= w_win_idx;
    end
  end

  assign bus.Valid = r_valid;
  assign bus.Grant = r_grant;
  assign bus.Idx   = r_idx;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter at width 8 and width 5 against a
// behavioural arbitration model, plus directed literal expectations.
module tb_rr_onehot_arbiter;
  import elau_arb_pkg::*;

`ifdef ELAU_RRARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic CLK  = 1'b0;
  logic RSTN = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  rr_onehot_arbiter_if #(.width(8)) if8();
  rr_onehot_arbiter_if #(.width(5)) if5();

  rr_onehot_arbiter #(.width(8)) u_dut8 (.CLK(CLK), .RSTN(RSTN), .bus(if8.slave));
  rr_onehot_arbiter #(.width(5)) u_dut5 (.CLK(CLK), .RSTN(RSTN), .bus(if5.slave));

  always #5 CLK = ~CLK;

  // Model state per DUT: valid flag, granted index, priority start point.
  int m_v[2];
  int m_i[2];
  int m_p[2];
  int mw[2] = '{8, 5};

  function automatic int pick(input logic [7:0] req, input int w, input int start);
    for (int k = 0; k < w; k++) begin
      int p = (start + k) % w;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  function automatic void mstep(input int d, input logic [7:0] req, input logic rdy);
    int st;
    int win;
    bit hs;
    hs = (m_v[d] != 0) && rdy;
    if (m_v[d] == 0 || rdy) begin
      if (!FAIR)   st = 0;
      else if (hs) st = (m_i[d] + 1) % mw[d];
      else         st = m_p[d];
      win = pick(req, mw[d], st);
      if (hs) m_p[d] = (m_i[d] + 1) % mw[d];
      m_v[d] = (win >= 0) ? 1 : 0;
      m_i[d] = (win >= 0) ? win : 0;
    end
  endfunction

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int d = 0; d < 2; d++) begin
        m_v[d] = 0;
        m_i[d] = 0;
        m_p[d] = 0;
      end
    end else begin
      mstep(0, if8.Req, if8.Ready);
      mstep(1, {3'b000, if5.Req}, if5.Ready);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_valid8", 32'(if8.Valid), 32'(m_v[0]));
      chk("model_grant8", 32'(if8.Grant), (m_v[0] != 0) ? (32'd1 << m_i[0]) : 32'd0);
      chk("model_idx8",   32'(if8.Idx),   32'(m_i[0]));
      chk("model_valid5", 32'(if5.Valid), 32'(m_v[1]));
      chk("model_grant5", 32'(if5.Grant), (m_v[1] != 0) ? (32'd1 << m_i[1]) : 32'd0);
      chk("model_idx5",   32'(if5.Idx),   32'(m_i[1]));
    end
  end

  initial begin
    logic [31:0] e;
    if8.Req = '0; if8.Ready = 1'b1;
    if5.Req = '0; if5.Ready = 1'b1;
    #1 RSTN = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_valid", 32'(if8.Valid), 32'd0);
    chk("rst_grant", 32'(if8.Grant), 32'd0);
    chk("rst_idx",   32'(if8.Idx),   32'd0);
    #1 RSTN = 1'b1;

    repeat (3) @(negedge CLK);
    chk("idle_valid", 32'(if8.Valid), 32'd0);

    // Rotation with all requesters active.
    if8.Req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      e = FAIR ? 32'(k % 8) : 32'd0;
      chk("rot_idx",   32'(if8.Idx),   e);
      chk("rot_grant", 32'(if8.Grant), 32'd1 << e);
    end

    // Asynchronous reset while a grant is held.
    chk("pre_rst_valid", 32'(if8.Valid), 32'd1);
    #2 RSTN = 1'b0;
    if8.Req = '0;
    #1;
    chk("async_rst_valid", 32'(if8.Valid), 32'd0);
    chk("async_rst_grant", 32'(if8.Grant), 32'd0);
    chk("async_rst_idx",   32'(if8.Idx),   32'd0);
    @(negedge CLK);
    #1 RSTN = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_rst_idle", 32'(if8.Valid), 32'd0);

    // Stall: grant held while Req changes.
    if8.Ready = 1'b0;
    if8.Req   = 8'h12;
    @(negedge CLK);
    chk("stall_first_grant", 32'(if8.Grant), 32'h02);
    chk("stall_first_idx",   32'(if8.Idx),   32'd1);
    if8.Req = 8'h80;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("stall_hold_grant", 32'(if8.Grant), 32'h02);
      chk("stall_hold_idx",   32'(if8.Idx),   32'd1);
      chk("stall_hold_valid", 32'(if8.Valid), 32'd1);
    end
    if8.Ready = 1'b1;
    @(negedge CLK);
    chk("stall_release_idx", 32'(if8.Idx), 32'd7);
    if8.Req = '0;
    @(negedge CLK);
    chk("stall_drain_valid", 32'(if8.Valid), 32'd0);

    // Dropped request.
    if8.Req = 8'h0C;
    @(negedge CLK);
    chk("drop_idx", 32'(if8.Idx), 32'd2);
    if8.Req = '0;
    @(negedge CLK);
    chk("drop_valid_fall", 32'(if8.Valid), 32'd0);
    repeat (2) @(negedge CLK);
    if8.Req = 8'h04;
    @(negedge CLK);
    chk("drop_regrant_idx", 32'(if8.Idx), 32'd2);
    if8.Req = '0;
    @(negedge CLK);

    // Non-power-of-two wrap on the width-5 instance.
    if5.Req = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      e = FAIR ? ((k % 2 == 1) ? 32'd4 : 32'd0) : 32'd0;
      chk("wrap5_idx", 32'(if5.Idx), e);
    end
    if5.Req = '0;
    @(negedge CLK);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      case ($urandom_range(0, 3))
        0:       if8.Req = '0;
        1:       if8.Req = 8'(32'd1 << $urandom_range(0, 7));
        default: if8.Req = 8'($urandom);
      endcase
      if5.Req   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      if8.Ready = ($urandom_range(0, 3) != 0);
      if5.Ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge CLK);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
